// File: rtl/instruction_memory_fetch.sv
// Instruction store for the MAC engine controller: field-wise external loading
// (explicit or auto-incrementing address) and a registered valid/ready fetch port.
module instruction_memory_fetch #(
    parameter int FIELDS      = 2,
    parameter int FIELD_WIDTH = 32,
    parameter int DEPTH       = 16,
    parameter int EXT_WIDTH   = 32,
    localparam int PC_W       = $clog2(DEPTH),
    localparam int FA_W       = $clog2(DEPTH*FIELDS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en_ext_im,
    input  logic [EXT_WIDTH-1:0]          wr_addr_ext_im,
    input  logic [EXT_WIDTH-1:0]          wr_data_ext_im,
    input  logic                          wr_auto_inc,
    input  logic                          load_restart,
    input  logic                          run_lock,
    output logic                          wr_err,
    output logic [PC_W:0]                 loaded_cnt,
    input  logic                          fetch_valid,
    input  logic [31:0]                   fetch_pc,
    output logic                          fetch_ready,
    output logic [FIELDS*FIELD_WIDTH-1:0] instr,
    output logic                          instr_valid,
    output logic                          instr_err,
    input  logic                          instr_ready
);

    // state | meaning
    // EMPTY | no fetched word held, instr_valid = 0
    // FULL  | instr holds a fetched word, instr_valid = 1

    localparam int N_FA = DEPTH * FIELDS;
    localparam int IW   = FIELDS * FIELD_WIDTH;
    localparam logic [PC_W:0] CNT_MAX = (PC_W+1)'(DEPTH);
    localparam logic [PC_W:0] CNT_ONE = (PC_W+1)'(1);
    localparam logic [FA_W-1:0] FA_ONE  = FA_W'(1);
    localparam logic [FA_W-1:0] FA_LAST = FA_W'(N_FA - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state, state_next;

    logic [FIELD_WIDTH-1:0] mem [N_FA];
    logic [FA_W-1:0]        wr_ptr;
    logic [FA_W-1:0]        base_ptr;
    logic [FA_W-1:0]        ptr_next;
    logic [FA_W-1:0]        wr_tgt;
    logic [PC_W:0]          base_cnt;
    logic                   addr_oob;
    logic                   wr_accept;
    logic                   wr_drop;
    logic                   tgt_last_field;
    logic                   fetch_accept;
    logic                   fetch_in_range;
    logic [PC_W-1:0]        rd_idx;
    logic [IW-1:0]          rd_word;

    // A restart in the same cycle as an auto-inc write rebases the pointer
    // first, so the write lands at address 0.
    always_comb begin
        base_ptr       = load_restart ? '0 : wr_ptr;
        base_cnt       = load_restart ? '0 : loaded_cnt;
        addr_oob       = !wr_auto_inc && (wr_addr_ext_im >= EXT_WIDTH'(N_FA));
        wr_tgt         = wr_auto_inc ? base_ptr : wr_addr_ext_im[FA_W-1:0];
        wr_drop        = wr_en_ext_im && (run_lock || addr_oob);
        wr_accept      = wr_en_ext_im && !run_lock && !addr_oob;
        ptr_next       = (base_ptr == FA_LAST) ? '0 : base_ptr + FA_ONE;
        tgt_last_field = ((32'(wr_tgt) % FIELDS) == FIELDS - 1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_FA; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            loaded_cnt <= '0;
            wr_err     <= 1'b0;
        end else begin
            wr_err     <= wr_drop;
            wr_ptr     <= base_ptr;
            loaded_cnt <= base_cnt;
            if (wr_accept) begin
                mem[wr_tgt] <= wr_data_ext_im[FIELD_WIDTH-1:0];
                if (wr_auto_inc) begin
                    wr_ptr <= ptr_next;
                    if (tgt_last_field && (base_cnt != CNT_MAX)) begin
                        loaded_cnt <= base_cnt + CNT_ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        fetch_in_range = (fetch_pc < 32'(DEPTH));
        rd_idx         = fetch_pc[PC_W-1:0];
        rd_word        = '0;
        for (int f = 0; f < FIELDS; f++) begin
            rd_word[f*FIELD_WIDTH +: FIELD_WIDTH] = mem[FA_W'(int'(rd_idx) * FIELDS + f)];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (fetch_accept) state_next = FULL;
            FULL: begin
                if (fetch_accept) begin
                    state_next = FULL;
                end else if (instr_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        instr_valid  = (state == FULL);
        fetch_ready  = (state != FULL) || instr_ready;
        fetch_accept = fetch_valid && fetch_ready;
    end

    // instr keeps its last value after being consumed; only instr_err is cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr     <= '0;
            instr_err <= 1'b0;
        end else if (fetch_accept) begin
            instr     <= fetch_in_range ? rd_word : '0;
            instr_err <= !fetch_in_range;
        end else if ((state == FULL) && instr_ready) begin
            instr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_memory_fetch.sv
// Scoreboard bench for instruction_memory_fetch: fetch expectations are queued at
// issue and checked by a negedge monitor when the consumer takes instr.
module tb_instruction_memory_fetch;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en_ext_im;
    logic [31:0] wr_addr_ext_im;
    logic [31:0] wr_data_ext_im;
    logic        wr_auto_inc;
    logic        load_restart;
    logic        run_lock;
    logic        wr_err;
    logic [4:0]  loaded_cnt;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic [63:0] instr;
    logic        instr_valid;
    logic        instr_err;
    logic        instr_ready;

    int n_checks = 0;
    int n_pass   = 0;
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;

    instruction_memory_fetch #(
        .FIELDS(2), .FIELD_WIDTH(32), .DEPTH(DEPTH), .EXT_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en_ext_im(wr_en_ext_im),
        .wr_addr_ext_im(wr_addr_ext_im),
        .wr_data_ext_im(wr_data_ext_im),
        .wr_auto_inc(wr_auto_inc),
        .load_restart(load_restart),
        .run_lock(run_lock),
        .wr_err(wr_err),
        .loaded_cnt(loaded_cnt),
        .fetch_valid(fetch_valid),
        .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_err(instr_err),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] w(input logic [31:0] f1, input logic [31:0] f0);
        return {f1, f0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch1(input int pc, input logic [63:0] d, input logic err);
        fetch_valid = 1'b1;
        fetch_pc    = 32'(pc);
        exp_q.push_back({err, d});
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic wr(input logic auto_i, input int addr, input logic [31:0] data,
                      input logic lock, input logic restart);
        wr_en_ext_im   = 1'b1;
        wr_auto_inc    = auto_i;
        wr_addr_ext_im = 32'(addr);
        wr_data_ext_im = data;
        run_lock       = lock;
        load_restart   = restart;
        tick();
        wr_en_ext_im = 1'b0;
        wr_auto_inc  = 1'b0;
        run_lock     = 1'b0;
        load_restart = 1'b0;
    endtask

    always @(negedge clk) begin
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_instr: got %0h with no queued expectation", instr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("instr", instr, mon_e[63:0]);
                chk("instr_err", 64'(instr_err), 64'(mon_e[64]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; wr_en_ext_im = 1'b0; wr_addr_ext_im = '0; wr_data_ext_im = '0;
        wr_auto_inc = 1'b0; load_restart = 1'b0; run_lock = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0; instr_ready = 1'b1;
        tick(); tick();
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", instr, 64'd0);
        chk("rst_loaded_cnt", 64'(loaded_cnt), 64'd0);
        chk("rst_wr_err", 64'(wr_err), 64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        reset = 1'b1;
        tick();

        // empty memory read back-to-back
        for (int pc = 0; pc < DEPTH; pc++) begin
            chk("t1_fetch_ready", 64'(fetch_ready), 64'd1);
            fetch1(pc, 64'd0, 1'b0);
        end
        tick();
        chk("t1_idle_valid", 64'(instr_valid), 64'd0);

        // auto-increment load with pointer wrap and count saturation
        load_restart = 1'b1; tick(); load_restart = 1'b0;
        for (int k = 0; k < 2*DEPTH; k++) begin
            wr(1'b1, 0, 32'(k), 1'b0, 1'b0);
            if (k == 3) chk("t2_cnt_partial", 64'(loaded_cnt), 64'd2);
        end
        chk("t2_cnt_full", 64'(loaded_cnt), 64'd16);
        wr(1'b1, 0, 32'hAAAA, 1'b0, 1'b0);
        chk("t2_wrap_wr_err", 64'(wr_err), 64'd0);
        wr(1'b1, 0, 32'hBBBB, 1'b0, 1'b0);
        chk("t2_cnt_sat", 64'(loaded_cnt), 64'd16);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) fetch1(0, w(32'hBBBB, 32'hAAAA), 1'b0);
            else        fetch1(i, w(32'(2*i+1), 32'(2*i)), 1'b0);
        end
        tick();

        // locked writes are dropped and do not move the pointer
        wr(1'b0, 3, 32'hDEAD, 1'b1, 1'b0);
        chk("t3_lock_err", 64'(wr_err), 64'd1);
        tick();
        chk("t3_err_pulse", 64'(wr_err), 64'd0);
        wr(1'b1, 0, 32'h1111, 1'b1, 1'b0);
        chk("t3_lock_auto_err", 64'(wr_err), 64'd1);
        wr(1'b1, 0, 32'h2222, 1'b0, 1'b0);
        chk("t3_auto_ok", 64'(wr_err), 64'd0);
        chk("t3_cnt_hold", 64'(loaded_cnt), 64'd16);
        fetch1(1, w(32'd3, 32'h2222), 1'b0);
        tick();

        // restart alone and restart coinciding with an auto-inc write
        wr(1'b1, 0, 32'h3333, 1'b0, 1'b1);
        chk("t3r_cnt_restart", 64'(loaded_cnt), 64'd0);
        wr(1'b1, 0, 32'h4444, 1'b0, 1'b0);
        chk("t3r_cnt_one", 64'(loaded_cnt), 64'd1);
        fetch1(0, w(32'h4444, 32'h3333), 1'b0);
        load_restart = 1'b1; tick(); load_restart = 1'b0;
        chk("t3r_cnt_clear", 64'(loaded_cnt), 64'd0);
        wr(1'b1, 0, 32'h5151, 1'b0, 1'b0);
        fetch1(0, w(32'h4444, 32'h5151), 1'b0);
        tick();

        // consumer stall holds the output and blocks the next request
        instr_ready = 1'b0;
        fetch_valid = 1'b1; fetch_pc = 32'd2;
        exp_q.push_back({1'b0, w(32'd5, 32'd4)});
        tick();
        fetch_pc = 32'd3;
        for (int c = 0; c < 3; c++) begin
            chk("t4_ready_low", 64'(fetch_ready), 64'd0);
            chk("t4_hold_instr", instr, w(32'd5, 32'd4));
            chk("t4_hold_valid", 64'(instr_valid), 64'd1);
            tick();
        end
        exp_q.push_back({1'b0, w(32'd7, 32'd6)});
        instr_ready = 1'b1;
        tick();
        fetch_valid = 1'b0;
        tick();

        // out-of-range fetch and write
        fetch1(DEPTH, 64'd0, 1'b1);
        tick();
        chk("t5_err_cleared", 64'(instr_err), 64'd0);
        chk("t5_idle_valid", 64'(instr_valid), 64'd0);
        wr(1'b0, 2*DEPTH, 32'h9999, 1'b0, 1'b0);
        chk("t5_oob_wr_err", 64'(wr_err), 64'd1);
        fetch1(0, w(32'h4444, 32'h5151), 1'b0);
        tick();

        // same-cycle write and fetch reads old content
        wr_en_ext_im = 1'b1; wr_auto_inc = 1'b0; wr_addr_ext_im = 32'd0; wr_data_ext_im = 32'h55;
        fetch_valid = 1'b1; fetch_pc = 32'd0;
        exp_q.push_back({1'b0, w(32'h4444, 32'h5151)});
        tick();
        wr_en_ext_im = 1'b0; fetch_valid = 1'b0;
        fetch1(0, w(32'h4444, 32'h55), 1'b0);
        tick();

        // reset while a word is held
        instr_ready = 1'b0;
        fetch_valid = 1'b1; fetch_pc = 32'd1;
        tick();
        fetch_valid = 1'b0;
        chk("t7_pre_valid", 64'(instr_valid), 64'd1);
        reset = 1'b0;
        tick();
        chk("t7_rst_valid", 64'(instr_valid), 64'd0);
        chk("t7_rst_instr", instr, 64'd0);
        chk("t7_rst_err", 64'(instr_err), 64'd0);
        chk("t7_rst_cnt", 64'(loaded_cnt), 64'd0);
        reset = 1'b1; instr_ready = 1'b1;
        tick();
        for (int pc = 0; pc < DEPTH; pc++) fetch1(pc, 64'd0, 1'b0);
        tick();
        wr(1'b1, 0, 32'h77, 1'b0, 1'b0);
        fetch1(0, w(32'd0, 32'h77), 1'b0);
        tick();

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) tick();
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected words never delivered, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
